// File: rtl/dna_ascii_unpacker_pkg.sv
// Shared datatypes for the DNA unpacker: 2-bit base encoding, unpacker
// states and the base-to-ASCII mapping.
package datatypesPkg;

    typedef enum logic [1:0] {
        nA = 2'd0,
        nC = 2'd1,
        nG = 2'd2,
        nT = 2'd3
    } dna_base;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EMIT    = 2'd1,
        NEWLINE = 2'd2
    } unpack_state_e;

    localparam logic [7:0] ASCII_NL = 8'h0A;

    function automatic logic [7:0] dna_to_ascii(input dna_base b);
        case (b)
            nA:      return 8'h41;
            nC:      return 8'h43;
            nG:      return 8'h47;
            default: return 8'h54;
        endcase
    endfunction

endpackage

// File: rtl/dna_ascii_unpacker.sv
// Unpacks words of 2-bit DNA bases into an ASCII character stream,
// optionally terminating each sequence with a newline.
module dna_ascii_unpacker
    import datatypesPkg::*;
#(
    parameter int BASES_PER_WORD = 16,
    parameter int EMIT_NEWLINE   = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [2*BASES_PER_WORD-1:0]       in_word,
    input  logic [$clog2(BASES_PER_WORD):0]   in_count,
    input  logic                              in_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [7:0]                        out_char,
    output logic                              out_last,
    output logic                              busy,
    output logic                              err_count
);

    localparam int CW    = $clog2(BASES_PER_WORD) + 1;
    localparam int IW    = (BASES_PER_WORD > 1) ? $clog2(BASES_PER_WORD) : 1;
    localparam int WW    = 2 * BASES_PER_WORD;
    localparam bit NL_EN = (EMIT_NEWLINE != 0);

    unpack_state_e state;
    logic [WW-1:0] word_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] idx;
    logic          last_q;
    logic          ready_en;

    logic [CW-1:0] idx_next;
    logic          out_fire;
    logic          final_base;
    logic          chain_ok;
    logic          in_fire;
    logic          in_legal;
    logic          first_last;
    logic          step_last;
    dna_base       next_base;
    dna_base       first_base;

    assign idx_next   = idx + CW'(1);
    assign out_fire   = out_valid && out_ready;
    assign final_base = (state == EMIT) && (idx_next == count_q);
    // A new word may only slip in while the final base leaves and no newline is owed.
    assign chain_ok   = final_base && out_ready && !(last_q && NL_EN);
    assign in_ready   = ready_en && ((state == IDLE) || chain_ok);
    assign in_fire    = in_valid && in_ready;
    assign in_legal   = (in_count <= CW'(BASES_PER_WORD));
    assign next_base  = dna_base'(word_q[{idx_next[IW-1:0], 1'b0} +: 2]);
    assign first_base = dna_base'(in_word[1:0]);
    assign first_last = (in_count == CW'(1)) && in_last && !NL_EN;
    assign step_last  = ((idx_next + CW'(1)) == count_q) && last_q && !NL_EN;
    assign busy       = (state != IDLE);

    // NOTE: pure datapath registers carry no reset; the control state guards their use.
    always_ff @(posedge clk) begin
        if (in_fire && in_legal) begin
            word_q  <= in_word;
            count_q <= in_count;
            last_q  <= in_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_char  <= 8'h00;
            err_count <= 1'b0;
            ready_en  <= 1'b0;
        end else begin
            err_count <= 1'b0;
            ready_en  <= 1'b1;
            case (state)
                EMIT: begin
                    if (out_fire) begin
                        if (final_base) begin
                            idx <= '0;
                            if (last_q && NL_EN) begin
                                state    <= NEWLINE;
                                out_char <= ASCII_NL;
                                out_last <= 1'b1;
                            end else begin
                                state     <= IDLE;
                                out_valid <= 1'b0;
                                out_last  <= 1'b0;
                            end
                        end else begin
                            idx      <= idx_next;
                            out_char <= dna_to_ascii(next_base);
                            out_last <= step_last;
                        end
                    end
                end
                NEWLINE: begin
                    if (out_fire) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // NOTE: non-blocking updates let this later word acceptance override the drain above.
            if (in_fire) begin
                if (!in_legal) begin
                    err_count <= 1'b1;
                end else if (in_count == '0) begin
                    if (in_last && NL_EN) begin
                        state     <= NEWLINE;
                        out_valid <= 1'b1;
                        out_char  <= ASCII_NL;
                        out_last  <= 1'b1;
                    end
                end else begin
                    state     <= EMIT;
                    idx       <= '0;
                    out_valid <= 1'b1;
                    out_char  <= dna_to_ascii(first_base);
                    out_last  <= first_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_dna_ascii_unpacker.sv
// Directed bench for dna_ascii_unpacker: character streams, backpressure,
// illegal counts and mid-word reset, checked against hand-computed strings.
module tb_dna_ascii_unpacker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic [4:0]  in_count;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_char;
    logic        out_last;
    logic        busy;
    logic        err_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int stalls = 0;

    byte  q_char[$];
    bit   q_last[$];
    int   q_cyc[$];
    bit   hold_pending = 1'b0;
    logic [7:0] held;

    dna_ascii_unpacker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .in_count  (in_count),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_char  (out_char),
        .out_last  (out_last),
        .busy      (busy),
        .err_count (err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Records each output transfer and verifies stalled characters are held.
    always begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", out_valid, 1);
                check("hold_char", out_char, held);
                hold_pending = 1'b0;
            end
            if (out_valid && out_ready) begin
                q_char.push_back(out_char);
                q_last.push_back(out_last);
                q_cyc.push_back(cyc);
            end else if (out_valid) begin
                hold_pending = 1'b1;
                held         = out_char;
                stalls++;
            end
        end
    end

    task automatic clear_q();
        q_char.delete();
        q_last.delete();
        q_cyc.delete();
    endtask

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic send(input logic [31:0] w, input logic [4:0] c, input logic l);
        int n = 0;
        in_word  = w;
        in_count = c;
        in_last  = l;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) check("send_ready_timeout", in_ready, 1);
        @(negedge clk);
    endtask

    task automatic wait_chars(input int n);
        int k = 0;
        while (q_char.size() < n && k < 500) begin
            @(negedge clk);
            #3;
            k++;
        end
        if (k >= 500) check("wait_chars_timeout", q_char.size(), n);
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic expect_str(input string tag, input string exp, input bit last_end);
        check({tag, "_len"}, q_char.size(), exp.len());
        for (int i = 0; i < exp.len() && i < q_char.size(); i++) begin
            check({tag, "_char"}, q_char[i], exp[i]);
            check({tag, "_last"}, q_last[i], (i == exp.len() - 1) && last_end);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        string exp;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_word   = '0;
        in_count  = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_char", out_char, 8'h00);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_count, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rel_in_ready", in_ready, 1);
        @(negedge clk);

        // "ACGT\n", first character one cycle after accept
        clear_q();
        send(32'h0000_00e4, 5'd4, 1'b1);
        in_valid = 1'b0;
        check("lat_valid", out_valid, 1);
        check("lat_char", out_char, 8'h41);
        check("lat_busy", busy, 1);
        wait_chars(5);
        settle();
        expect_str("acgt", "ACGT\n", 1'b1);
        if (q_cyc.size() >= 5) check("acgt_span", q_cyc[4] - q_cyc[0], 4);
        check("acgt_idle", busy, 0);

        // Two full words back to back with no bubble
        clear_q();
        send(32'he4e4_e4e4, 5'd16, 1'b0);
        send(32'h1b1b_1b1b, 5'd16, 1'b1);
        in_valid = 1'b0;
        wait_chars(33);
        settle();
        exp = "";
        for (int i = 0; i < 4; i++) exp = {exp, "ACGT"};
        for (int i = 0; i < 4; i++) exp = {exp, "TGCA"};
        exp = {exp, "\n"};
        expect_str("b2b", exp, 1'b1);
        if (q_cyc.size() >= 33) check("b2b_span", q_cyc[32] - q_cyc[0], 32);

        // Backpressure toggling every cycle on a 3-base word
        clear_q();
        stalls = 0;
        fork
            begin
                send(32'h0000_00e4, 5'd3, 1'b0);
                in_valid = 1'b0;
            end
            begin
                repeat (12) begin
                    @(negedge clk);
                    out_ready = ~out_ready;
                end
            end
        join
        out_ready = 1'b1;
        wait_chars(3);
        settle();
        expect_str("acg", "ACG", 1'b0);
        check("stalls_seen", stalls > 0, 1);

        // Illegal count, then an empty final word
        clear_q();
        send(32'hffff_ffff, 5'd17, 1'b0);
        in_valid = 1'b0;
        check("ill_err", err_count, 1);
        check("ill_busy", busy, 0);
        check("ill_valid", out_valid, 0);
        @(negedge clk);
        check("ill_err_pulse", err_count, 0);
        settle();
        check("ill_no_out", q_char.size(), 0);
        send(32'h0, 5'd0, 1'b1);
        in_valid = 1'b0;
        check("nl_valid", out_valid, 1);
        check("nl_char", out_char, 8'h0A);
        check("nl_last", out_last, 1);
        wait_chars(1);
        settle();
        expect_str("nl_only", "\n", 1'b1);

        // Reset after the second of eight characters
        clear_q();
        send(32'h0000_e4e4, 5'd8, 1'b1);
        in_valid = 1'b0;
        wait_chars(2);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_last", out_last, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expect_str("pre_rst", "AC", 1'b0);
        clear_q();
        send(32'h0000_0003, 5'd1, 1'b1);
        in_valid = 1'b0;
        wait_chars(2);
        settle();
        expect_str("post_rst", "T\n", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dna_ascii_unpacker.md
DNA_ASCII_UNPACKER -- requirements
Module: dna_ascii_unpacker

Interface
REQ-001 Parameter BASES_PER_WORD, default 16: number of 2-bit dna_base fields per input word.
REQ-002 Parameter EMIT_NEWLINE, default 1: when 1, a 0x0A terminator character follows the last base of a sequence.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  producer presents a packed word.
REQ-006 in_ready  output  1  block accepts the word this cycle.
REQ-007 in_word  input  2*BASES_PER_WORD  packed dna_base values; base i is in bits [2i+1:2i]; base 0 is emitted first.
REQ-008 in_count  input  $clog2(BASES_PER_WORD)+1  number of valid bases in in_word (0..BASES_PER_WORD).
REQ-009 in_last  input  1  word ends the current sequence.
REQ-010 out_valid  output  1  out_char is valid.
REQ-011 out_ready  input  1  consumer accepts out_char this cycle.
REQ-012 out_char  output  8  ASCII character.
REQ-013 out_last  output  1  final character of the sequence.
REQ-014 busy  output  1  FSM is not in IDLE.
REQ-015 err_count  output  1  one-cycle pulse on an illegal word.

Function
REQ-016 Mapping: nA->0x41, nC->0x43, nG->0x47, nT->0x54.
REQ-017 Input transfer: in_valid and in_ready high on the same rising edge; output transfer: out_valid and out_ready high on the same rising edge.
REQ-018 FSM states: IDLE, EMIT, NEWLINE.
REQ-019 IDLE: in_ready=1; a transfer with 1<=in_count<=BASES_PER_WORD latches word, count and last, and moves to EMIT with out_valid=1 on the next cycle (latency 1).
REQ-020 EMIT: out_char is the base at the current index; each output transfer advances the index by 1.
REQ-021 EMIT: out_last=1 only on the final base when latched last=1 and EMIT_NEWLINE=0.
REQ-022 Final base accepted, latched last=1, EMIT_NEWLINE=1: go to NEWLINE; NEWLINE drives out_char=0x0A and out_last=1, then returns to IDLE on transfer.
REQ-023 Final base accepted otherwise: return to IDLE, or take a new word in the same cycle (REQ-024).
REQ-024 In EMIT, in_ready=1 only in the cycle the final base transfers and no NEWLINE follows; a word accepted then is emitted with no bubble, giving one character per cycle sustained.
REQ-025 NEWLINE: in_ready=0.
REQ-026 out_valid, once high, stays high and out_char/out_last stay stable until the transfer (no withdrawal under backpressure).
REQ-027 in_count=0 word: accepted, no characters emitted; if in_last=1 and EMIT_NEWLINE=1, only 0x0A with out_last=1 is emitted.
REQ-028 in_count>BASES_PER_WORD: word accepted and dropped, err_count pulses for 1 cycle, state unchanged.
REQ-029 Reset mid-operation: the partially emitted word is discarded; no further characters of it appear.

Reset
REQ-030 On rst_n low, asynchronously: state=IDLE, index=0, out_valid=0, out_last=0, out_char=0x00, err_count=0, busy=0; in_ready=1 from the first edge after release.

Structure
REQ-031 dna_base and an ASCII-mapping function (dna_base to 8-bit) belong in datatypesPkg, alongside a new unpacker-state enum.
REQ-032 Single module with no sub-modules; the base-select mux is inline.

Verification
REQ-033 Word {nA,nC,nG,nT}, count=4, last=1, out_ready=1 -> "ACGT\n" on consecutive cycles; out_last only on 0x0A; first char 1 cycle after accept.
REQ-034 Two back-to-back words, count=16, last=0 then 1, out_ready=1 -> 32 characters plus 0x0A with no idle cycle between the words.
REQ-035 out_ready toggled 1/0 every cycle during a 3-base word -> every char is held stable while stalled; output "ACG" order is preserved.
REQ-036 in_count=17 -> err_count pulses 1 cycle, no output; then count=0, last=1 -> a single 0x0A with out_last=1.
REQ-037 rst_n asserted after the 2nd of 8 chars -> out_valid=0 immediately; after release, a new 1-base word nT -> "T\n" only.
